// File: rtl/series_arb_pkg.sv
// -----------------------------------------------------------------------------
// series_arb_pkg
// Shared definitions for the series-evaluation arbiter:
//   - state_t       : arbiter FSM states
//   - *_DEF         : default parameter values for series_arbiter
// -----------------------------------------------------------------------------
package series_arb_pkg;

  localparam int N_REQ_DEF   = 4;
  localparam int X_W_DEF     = 8;
  localparam int RES_W_DEF   = 16;
  localparam int TIMEOUT_DEF = 1023;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    RESP      = 3'd4
  } state_t;

endpackage

// File: rtl/series_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin selector. Finds the first set bit of req_i at or
// above ptr_i, wrapping modulo N.
//   req_i    : request vector
//   ptr_i    : search start index
//   any_o    : at least one request is set
//   winner_o : index of the selected request (0 when any_o is low)
//   grant_o  : one-hot form of winner_o (all zero when any_o is low)
// -----------------------------------------------------------------------------
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          any_o,
  output logic [IW-1:0] winner_o,
  output logic [N-1:0]  grant_o
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] masked;
  logic           found;

  // The request vector is duplicated and the bits below ptr_i are masked off
  // in the lower copy; the upper copy is unmasked, so a plain lowest-bit
  // search over the doubled vector realises the wrap-around.
  always_comb begin
    dbl      = {req_i, req_i};
    masked   = '0;
    found    = 1'b0;
    winner_o = '0;
    for (int i = 0; i < 2 * N; i++) begin
      masked[i] = dbl[i] && (i >= int'(ptr_i));
    end
    for (int i = 0; i < 2 * N; i++) begin
      if (!found && masked[i]) begin
        found    = 1'b1;
        winner_o = (i >= N) ? IW'(i - N) : IW'(i);
      end
    end
    any_o   = |req_i;
    grant_o = any_o ? (N'(1) << winner_o) : '0;
  end

endmodule

// File: rtl/series_arbiter.sv
// -----------------------------------------------------------------------------
// series_arbiter
// Round-robin scheduler sharing one iterative series-evaluation unit among
// N_REQ clients, with a per-job timeout.
//
// Handshakes: a client request i is accepted in the cycle where
// req_valid[i] && req_ready[i]; a response i is consumed in the cycle where
// resp_valid[i] && resp_ready[i]. req_ready is a combinational one-cycle
// accept pulse issued only in IDLE; resp_valid is held until consumed.
//
// Ports:
//   clk, rst              : clock / async active-high reset
//   req_valid, req_x      : client requests and packed operands
//   req_ready             : one-hot accept pulse
//   resp_valid/ready      : one-hot response handshake
//   resp_res, resp_err    : shared result bus and timeout flag
//   unit_start, unit_x    : evaluation unit start pulse and operand
//   unit_ready, unit_res  : evaluation unit idle/done and result
//   busy, grant_id        : job-in-flight flag, current/last granted client
//   dbg_state             : FSM state for observation
// -----------------------------------------------------------------------------
module series_arbiter
  import series_arb_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int X_W     = X_W_DEF,
  parameter int RES_W   = RES_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int IW      = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [N_REQ*X_W-1:0] req_x,
  output logic [N_REQ-1:0]     req_ready,
  output logic [N_REQ-1:0]     resp_valid,
  input  logic [N_REQ-1:0]     resp_ready,
  output logic [RES_W-1:0]     resp_res,
  output logic                 resp_err,
  output logic                 unit_start,
  output logic [X_W-1:0]       unit_x,
  input  logic                 unit_ready,
  input  logic [RES_W-1:0]     unit_res,
  output logic                 busy,
  output logic [IW-1:0]        grant_id,
  output state_t               dbg_state
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t           state_q;
  logic [IW-1:0]    rr_ptr_q;
  logic [IW-1:0]    grant_q;
  logic [X_W-1:0]   x_q;
  logic [RES_W-1:0] res_q;
  logic             err_q;
  logic [TW-1:0]    tcnt_q;
  logic             unit_start_q;
  logic [N_REQ-1:0] resp_valid_q;

  logic             pick_any;
  logic [IW-1:0]    pick_win;
  logic [N_REQ-1:0] pick_oh;

  rr_picker #(.N(N_REQ), .IW(IW)) u_picker (
    .req_i    (req_valid),
    .ptr_i    (rr_ptr_q),
    .any_o    (pick_any),
    .winner_o (pick_win),
    .grant_o  (pick_oh)
  );

  logic          grant_now;
  logic          resp_hs;
  logic          timeout_hit;
  logic [TW-1:0] tcnt_inc;
  logic [IW-1:0] next_ptr;

  assign grant_now   = (state_q == IDLE) && unit_ready && pick_any;
  assign resp_hs     = (state_q == RESP) && resp_ready[grant_q];
  assign timeout_hit = (tcnt_q == TW'(TIMEOUT));
  // Saturate at TIMEOUT so a limit reached while leaving WAIT_BUSY is still
  // seen by the equality compare in WAIT_DONE.
  assign tcnt_inc    = timeout_hit ? tcnt_q : tcnt_q + TW'(1);
  assign next_ptr    = (grant_q == IW'(N_REQ - 1)) ? '0 : grant_q + IW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      x_q          <= '0;
      res_q        <= '0;
      err_q        <= 1'b0;
      tcnt_q       <= '0;
      unit_start_q <= 1'b0;
      resp_valid_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_now) begin
            x_q          <= req_x[pick_win*X_W +: X_W];
            grant_q      <= pick_win;
            tcnt_q       <= '0;
            unit_start_q <= 1'b1;
            state_q      <= START;
          end
        end
        START: begin
          unit_start_q <= 1'b0;
          tcnt_q       <= tcnt_inc;
          state_q      <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          tcnt_q <= tcnt_inc;
          if (!unit_ready) begin
            state_q <= WAIT_DONE;
          end else if (timeout_hit) begin
            res_q        <= '0;
            err_q        <= 1'b1;
            resp_valid_q <= N_REQ'(1) << grant_q;
            state_q      <= RESP;
          end
        end
        WAIT_DONE: begin
          tcnt_q <= tcnt_inc;
          if (unit_ready) begin
            res_q        <= unit_res;
            err_q        <= 1'b0;
            resp_valid_q <= N_REQ'(1) << grant_q;
            state_q      <= RESP;
          end else if (timeout_hit) begin
            res_q        <= '0;
            err_q        <= 1'b1;
            resp_valid_q <= N_REQ'(1) << grant_q;
            state_q      <= RESP;
          end
        end
        RESP: begin
          if (resp_hs) begin
            rr_ptr_q     <= next_ptr;
            resp_valid_q <= '0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = grant_now ? pick_oh : '0;
  assign resp_valid = resp_valid_q;
  assign resp_res   = (state_q == RESP) ? res_q : '0;
  assign resp_err   = (state_q == RESP) && err_q;
  assign unit_start = unit_start_q;
  assign unit_x     = x_q;
  assign busy       = (state_q != IDLE);
  assign grant_id   = grant_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_series_arbiter.sv
// -----------------------------------------------------------------------------
// tb_series_arbiter
// Self-checking bench for series_arbiter with a behavioural unit model and a
// round-robin reference model. Grants push expected responses into exp_q; the
// monitor pops and compares them when responses are consumed.
// -----------------------------------------------------------------------------
module tb_series_arbiter;
  import series_arb_pkg::*;

  localparam int N  = 4;
  localparam int XW = 8;
  localparam int RW = 16;
  localparam int TO = 20;
  localparam int IW = 2;
  localparam int EW = 1 + IW + RW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid = '0;
  logic [N*XW-1:0] req_x     = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    resp_valid;
  logic [N-1:0]    resp_ready = '1;
  logic [RW-1:0]   resp_res;
  logic            resp_err;
  logic            unit_start;
  logic [XW-1:0]   unit_x;
  logic            unit_ready = 1'b1;
  logic [RW-1:0]   unit_res   = '0;
  logic            busy;
  logic [IW-1:0]   grant_id;
  state_t          dbg_state;

  series_arbiter #(.N_REQ(N), .X_W(XW), .RES_W(RW), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_x      (req_x),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_res   (resp_res),
    .resp_err   (resp_err),
    .unit_start (unit_start),
    .unit_x     (unit_x),
    .unit_ready (unit_ready),
    .unit_res   (unit_res),
    .busy       (busy),
    .grant_id   (grant_id),
    .dbg_state  (dbg_state)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_bound(input string name, input int waited);
    total++;
    bad++;
    $display("FAIL %s: waited %0d cycles without the awaited event", name, waited);
  endtask

  // ---------------- unit model ----------------
  // Ready drops the cycle start is seen and returns lat cycles after the
  // start cycle; in stall mode it stays low until stall is cleared.
  int            lat      = 10;
  bit            stall    = 1'b0;
  bit            force_en = 1'b0;
  logic [RW-1:0] force_res = 16'h1234;
  int            ucnt     = 0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        unit_ready = 1'b1;
        ucnt       = 0;
      end else if (ucnt > 0) begin
        ucnt--;
        if (ucnt == 0 && !stall) begin
          unit_ready = 1'b1;
          unit_res   = force_en ? force_res : {unit_x, ~unit_x};
        end
      end else if (!unit_ready && !stall) begin
        unit_ready = 1'b1;
      end else if (unit_start) begin
        unit_ready = 1'b0;
        ucnt       = lat;
      end
    end
  end

  // ---------------- reference model + monitor ----------------
  logic [EW-1:0] exp_q[$];
  int            grant_log[$];
  int            ref_ptr   = 0;
  bit            ref_busy  = 1'b0;
  int            grant_cyc = -10;
  int            job_lat   = 0;
  bit            resp_seen = 1'b0;
  int            cyc       = 0;

  function automatic int ref_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  initial begin
    forever begin
      int            w;
      logic [N-1:0]  exp_oh;
      bit            exp_st;
      logic [EW-1:0] e;
      int            id;
      logic [XW-1:0] gx;
      logic [RW-1:0] eres;
      @(negedge clk);
      cyc++;
      if (rst) begin
        exp_q.delete();
        ref_ptr  = 0;
        ref_busy = 1'b0;
      end else begin
        w      = (!ref_busy && unit_ready) ? ref_pick(req_valid, ref_ptr) : -1;
        exp_oh = (w >= 0) ? (N'(1) << w) : '0;
        if (exp_oh != 0 || req_ready != 0) check("req_ready", 32'(req_ready), 32'(exp_oh));

        exp_st = ref_busy && (cyc == grant_cyc + 1);
        if (exp_st || unit_start) check("unit_start", 32'(unit_start), 32'(exp_st));
        if (exp_st) check("grant_id", 32'(grant_id), 32'(grant_log[grant_log.size()-1]));

        if (resp_valid != 0) begin
          if (exp_q.size() == 0) begin
            check("resp_unexpected", 32'(resp_valid), 32'd0);
          end else begin
            e  = exp_q[0];
            id = int'(e[RW+IW-1:RW]);
            check("resp_valid", 32'(resp_valid), 32'(N'(1) << id));
            check("resp_res", 32'(resp_res), 32'(e[RW-1:0]));
            check("resp_err", 32'(resp_err), 32'(e[EW-1]));
            if (!resp_seen) begin
              check("resp_latency", 32'(cyc - grant_cyc), 32'(job_lat));
              resp_seen = 1'b1;
            end
            if (resp_ready[id]) begin
              void'(exp_q.pop_front());
              ref_ptr  = (id + 1) % N;
              ref_busy = 1'b0;
            end
          end
        end

        if (w >= 0) begin
          gx        = req_x[w*XW +: XW];
          eres      = stall ? '0 : (force_en ? force_res : {gx, ~gx});
          ref_busy  = 1'b1;
          grant_cyc = cyc;
          resp_seen = 1'b0;
          job_lat   = stall ? TO + 2 : lat + 2;
          grant_log.push_back(w);
          exp_q.push_back({stall, IW'(w), eres});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_grants(input int n, input int budget);
    int k = 0;
    while (grant_log.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    if (k >= budget) fail_bound("wait_grant", k);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((busy || ref_busy || exp_q.size() != 0) && k < budget) begin
      tick(1);
      k++;
    end
    if (k >= budget) fail_bound("wait_idle", k);
  endtask

  task automatic one_job(input int id, input logic [XW-1:0] x);
    int n0 = grant_log.size();
    req_x[id*XW +: XW] = x;
    req_valid[id]      = 1'b1;
    wait_grants(n0 + 1, 100);
    req_valid[id] = 1'b0;
    wait_idle(200);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    check({tag, "_resp_res"}, 32'(resp_res), 32'd0);
    check({tag, "_resp_err"}, 32'(resp_err), 32'd0);
    check({tag, "_unit_start"}, 32'(unit_start), 32'd0);
    check({tag, "_unit_x"}, 32'(unit_x), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_grant_id"}, 32'(grant_id), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n0;
    tick(3);
    check_outputs_zero("reset");
    rst = 1'b0;
    tick(2);

    // Single request, client 2, fixed result.
    lat = 10; force_en = 1'b1; force_res = 16'h1234;
    one_job(2, 8'h05);
    force_en = 1'b0;

    // Fairness from a fresh pointer.
    rst = 1'b1; tick(2); rst = 1'b0; tick(2);
    lat = 4;
    for (int i = 0; i < N; i++) req_x[i*XW +: XW] = XW'($urandom_range(0, 255));
    grant_log.delete();
    req_valid = '1;
    wait_grants(5, 200);
    req_valid = '0;
    wait_idle(200);
    for (int i = 0; i < 5; i++) check("fair_order", 32'(grant_log[i]), 32'(i % N));

    // Pointer wrap: grant 3, then only 3 and 0 valid.
    one_job(3, 8'h3c);
    grant_log.delete();
    req_valid = 4'b1001;
    wait_grants(2, 200);
    req_valid = '0;
    wait_idle(200);
    check("wrap_first", 32'(grant_log[0]), 32'd0);
    check("wrap_second", 32'(grant_log[1]), 32'd3);

    // Randomised bursts.
    for (int b = 0; b < 6; b++) begin
      lat = $urandom_range(2, 8);
      for (int c = 0; c < 60; c++) begin
        req_valid  = N'($urandom_range(0, 15));
        req_x      = {XW'($urandom), XW'($urandom), XW'($urandom), XW'($urandom)};
        resp_ready = N'($urandom_range(0, 15));
        tick(1);
      end
      req_valid  = '0;
      resp_ready = '1;
      wait_idle(200);
    end

    // Backpressure on client 1; other ready bits high must be ignored.
    lat = 3;
    resp_ready = 4'b1101;
    n0 = grant_log.size();
    req_x[1*XW +: XW] = 8'ha7;
    req_valid[1] = 1'b1;
    wait_grants(n0 + 1, 100);
    req_valid[1] = 1'b0;
    begin
      int k = 0;
      while (resp_valid == 0 && k < 50) begin tick(1); k++; end
      if (k >= 50) fail_bound("bp_resp", k);
    end
    tick(5);
    check("bp_held_valid", 32'(resp_valid), 32'b0010);
    check("bp_no_new_grant", 32'(grant_log.size()), 32'(n0 + 1));
    resp_ready = '1;
    wait_idle(50);

    // Timeout with a stalled unit, then no grant while unit_ready is low.
    stall = 1'b1; lat = 3;
    n0 = grant_log.size();
    req_x[1*XW +: XW] = 8'h11;
    req_valid[1] = 1'b1;
    wait_grants(n0 + 1, 100);
    req_valid[1] = 1'b0;
    begin
      int k = 0;
      while (exp_q.size() != 0 && k < 60) begin tick(1); k++; end
      if (k >= 60) fail_bound("timeout_resp", k);
    end
    req_valid = '1;
    tick(10);
    check("no_grant_stalled", 32'(grant_log.size()), 32'(n0 + 1));
    req_valid = '0;
    stall = 1'b0;
    tick(3);
    wait_idle(100);
    one_job(0, 8'h42);

    // Reset during WAIT_DONE; pending response must vanish.
    lat = 10;
    one_job(1, 8'h21);
    n0 = grant_log.size();
    req_x[2*XW +: XW] = 8'h99;
    req_valid[2] = 1'b1;
    wait_grants(n0 + 1, 100);
    req_valid[2] = 1'b0;
    tick(5);
    check("pre_rst_state", 32'(dbg_state), 32'(WAIT_DONE));
    rst = 1'b1;
    #1;
    check_outputs_zero("midrst");
    tick(2);
    rst = 1'b0;
    tick(15);
    n0 = grant_log.size();
    req_valid = '1;
    wait_grants(n0 + 1, 100);
    req_valid = '0;
    check("post_rst_grant", 32'(grant_log[grant_log.size()-1]), 32'd0);
    wait_idle(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
